// File: rtl/threshold_monitor_pkg.sv
// rtl/threshold_monitor_pkg.sv - shared types, defaults and sample classifier for threshold_monitor
package threshold_monitor_pkg;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_DEBOUNCE = 3;
  localparam int DEF_CNT_W    = 8;

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_LOW_PEND  = 2'd1,
    S_HIGH      = 2'd2,
    S_HIGH_PEND = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CLS_L = 2'd0,
    CLS_N = 2'd1,
    CLS_H = 2'd2
  } cls_t;

  // Equal (or any malformed comparator code) is treated as neutral so it holds the FSM.
  function automatic cls_t classify(input logic eq, input logic gt, input logic lt);
    cls_t c;
    case ({eq, gt, lt})
      3'b010:  c = CLS_H;
      3'b001:  c = CLS_L;
      3'b100:  c = CLS_N;
      default: c = CLS_N;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/threshold_monitor_if.sv
// rtl/threshold_monitor_if.sv - sample stream and status bundle for threshold_monitor
interface threshold_monitor_if
  import threshold_monitor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) ();

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] thresh;
  logic             clear;

  logic             state_above;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [CNT_W-1:0] event_cnt;
  logic             cnt_sat;
  logic [WIDTH-1:0] max_val;
  logic [WIDTH-1:0] min_val;

  modport master (
    output in_valid, in_data, thresh, clear,
    input  state_above, rise_pulse, fall_pulse, event_cnt, cnt_sat, max_val, min_val
  );

  modport slave (
    input  in_valid, in_data, thresh, clear,
    output state_above, rise_pulse, fall_pulse, event_cnt, cnt_sat, max_val, min_val
  );

endinterface

// File: rtl/comparator.sv
// rtl/comparator.sv - unsigned magnitude comparator
module comparator #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             AequalB,
  output logic             greater,
  output logic             lesser
);

  assign AequalB = (A == B);
  assign greater = (A > B);
  assign lesser  = (A < B);

endmodule

// File: rtl/threshold_monitor.sv
// rtl/threshold_monitor.sv - debounced threshold crossing detector with event count and min/max
module threshold_monitor
  import threshold_monitor_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEBOUNCE = DEF_DEBOUNCE,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic          clk,
  input  logic          rst_n,
  threshold_monitor_if.slave bus
);

  localparam logic [3:0]       DEB_N   = 4'(DEBOUNCE);
  localparam logic [3:0]       DEB_ONE = 4'd1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic a_eq_b, a_gt_b, a_lt_b;
  logic accept;
  cls_t cls;

  state_t     state, state_nxt;
  logic [3:0] deb, deb_nxt;

  logic             rise_evt, fall_evt, above_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  comparator #(.WIDTH(WIDTH)) u_cmp (
    .A       (bus.in_data),
    .B       (bus.thresh),
    .AequalB (a_eq_b),
    .greater (a_gt_b),
    .lesser  (a_lt_b)
  );

  // A clear in the same cycle discards the sample entirely.
  assign accept = bus.in_valid && !bus.clear;
  assign cls    = classify(a_eq_b, a_gt_b, a_lt_b);

  // State register: FSM state and debounce count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_LOW;
      deb   <= 4'd0;
    end else if (bus.clear) begin
      state <= S_LOW;
      deb   <= 4'd0;
    end else begin
      state <= state_nxt;
      deb   <= deb_nxt;
    end
  end

  // Next-state: only accepted samples move the FSM; idle cycles leave a pending run intact.
  always_comb begin
    state_nxt = state;
    deb_nxt   = deb;
    if (accept) begin
      case (state)
        S_LOW: begin
          if (cls == CLS_H) begin
            if (DEB_N == DEB_ONE) begin
              state_nxt = S_HIGH;
            end else begin
              state_nxt = S_LOW_PEND;
              deb_nxt   = DEB_ONE;
            end
          end
        end
        S_LOW_PEND: begin
          if (cls == CLS_H) begin
            if (deb + DEB_ONE == DEB_N) begin
              state_nxt = S_HIGH;
              deb_nxt   = 4'd0;
            end else begin
              deb_nxt = deb + DEB_ONE;
            end
          end else begin
            state_nxt = S_LOW;
            deb_nxt   = 4'd0;
          end
        end
        S_HIGH: begin
          if (cls == CLS_L) begin
            if (DEB_N == DEB_ONE) begin
              state_nxt = S_LOW;
            end else begin
              state_nxt = S_HIGH_PEND;
              deb_nxt   = DEB_ONE;
            end
          end
        end
        S_HIGH_PEND: begin
          if (cls == CLS_L) begin
            if (deb + DEB_ONE == DEB_N) begin
              state_nxt = S_LOW;
              deb_nxt   = 4'd0;
            end else begin
              deb_nxt = deb + DEB_ONE;
            end
          end else begin
            state_nxt = S_HIGH;
            deb_nxt   = 4'd0;
          end
        end
        default: begin
          state_nxt = S_LOW;
          deb_nxt   = 4'd0;
        end
      endcase
    end
  end

  // Output decode: events are transitions between the low and high halves of the FSM.
  always_comb begin
    rise_evt  = 1'b0;
    fall_evt  = 1'b0;
    above_nxt = (state_nxt == S_HIGH) || (state_nxt == S_HIGH_PEND);
    if (accept) begin
      rise_evt = ((state == S_LOW) || (state == S_LOW_PEND)) && (state_nxt == S_HIGH);
      fall_evt = ((state == S_HIGH) || (state == S_HIGH_PEND)) && (state_nxt == S_LOW);
    end
    cnt_nxt = bus.event_cnt;
    if ((rise_evt || fall_evt) && (bus.event_cnt != CNT_MAX)) begin
      cnt_nxt = bus.event_cnt + CNT_ONE;
    end
  end

  // Output registers: level, pulses, saturating count and running extremes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.state_above <= 1'b0;
      bus.rise_pulse  <= 1'b0;
      bus.fall_pulse  <= 1'b0;
      bus.event_cnt   <= '0;
      bus.cnt_sat     <= 1'b0;
      bus.max_val     <= '0;
      bus.min_val     <= '1;
    end else if (bus.clear) begin
      bus.state_above <= 1'b0;
      bus.rise_pulse  <= 1'b0;
      bus.fall_pulse  <= 1'b0;
      bus.event_cnt   <= '0;
      bus.cnt_sat     <= 1'b0;
      bus.max_val     <= '0;
      bus.min_val     <= '1;
    end else begin
      bus.state_above <= above_nxt;
      bus.rise_pulse  <= rise_evt;
      bus.fall_pulse  <= fall_evt;
      bus.event_cnt   <= cnt_nxt;
      bus.cnt_sat     <= (cnt_nxt == CNT_MAX);
      if (accept) begin
        if (bus.in_data > bus.max_val) bus.max_val <= bus.in_data;
        if (bus.in_data < bus.min_val) bus.min_val <= bus.in_data;
      end
    end
  end

endmodule

// File: tb/tb_threshold_monitor.sv
// tb/tb_threshold_monitor.sv - scoreboard bench for threshold_monitor
`timescale 1ns/1ps
module tb_threshold_monitor;

  logic clk;
  logic rst_n;

  threshold_monitor_if #(.WIDTH(4), .CNT_W(8)) bus_a ();
  threshold_monitor_if #(.WIDTH(4), .CNT_W(2)) bus_b ();

  threshold_monitor #(.WIDTH(4), .DEBOUNCE(3), .CNT_W(8)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  threshold_monitor #(.WIDTH(4), .DEBOUNCE(3), .CNT_W(2)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  typedef struct {
    int   idx;
    logic above;
    logic rise;
    logic fall;
    int   cnt;
    int   mx;
    int   mn;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   step_no = 0;

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input int d, input int th, input logic c);
    bus_a.in_valid = v;  bus_b.in_valid = v;
    bus_a.in_data  = 4'(d); bus_b.in_data  = 4'(d);
    bus_a.thresh   = 4'(th); bus_b.thresh  = 4'(th);
    bus_a.clear    = c;  bus_b.clear    = c;
  endtask

  // One stimulus cycle; the expectation describes the outputs after the accepting edge.
  task automatic step(input logic v, input int d, input int th, input logic c,
                      input logic ab, input logic r, input logic f,
                      input int cnt, input int mx, input int mn);
    exp_t e;
    @(negedge clk);
    drive(v, d, th, c);
    step_no++;
    e.idx = step_no; e.above = ab; e.rise = r; e.fall = f;
    e.cnt = cnt; e.mx = mx; e.mn = mn;
    sb.push_back(e);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_a_above"}, int'(bus_a.state_above), 0);
    chk({tag, "_a_rise"},  int'(bus_a.rise_pulse), 0);
    chk({tag, "_a_fall"},  int'(bus_a.fall_pulse), 0);
    chk({tag, "_a_cnt"},   int'(bus_a.event_cnt), 0);
    chk({tag, "_a_sat"},   int'(bus_a.cnt_sat), 0);
    chk({tag, "_a_max"},   int'(bus_a.max_val), 0);
    chk({tag, "_a_min"},   int'(bus_a.min_val), 15);
    chk({tag, "_b_cnt"},   int'(bus_b.event_cnt), 0);
    chk({tag, "_b_sat"},   int'(bus_b.cnt_sat), 0);
    chk({tag, "_b_rise"},  int'(bus_b.rise_pulse), 0);
  endtask

  // Monitor: after every clock edge, pop one expectation if the driver issued one.
  initial begin
    exp_t e;
    int   bc;
    forever begin
      @(posedge clk);
      #3;
      if (sb.size() > 0) begin
        e  = sb.pop_front();
        bc = (e.cnt > 3) ? 3 : e.cnt;
        chk($sformatf("s%0d_above", e.idx),  int'(bus_a.state_above), int'(e.above));
        chk($sformatf("s%0d_rise", e.idx),   int'(bus_a.rise_pulse),  int'(e.rise));
        chk($sformatf("s%0d_fall", e.idx),   int'(bus_a.fall_pulse),  int'(e.fall));
        chk($sformatf("s%0d_cnt", e.idx),    int'(bus_a.event_cnt),   e.cnt);
        chk($sformatf("s%0d_sat", e.idx),    int'(bus_a.cnt_sat),     (e.cnt == 255) ? 1 : 0);
        chk($sformatf("s%0d_max", e.idx),    int'(bus_a.max_val),     e.mx);
        chk($sformatf("s%0d_min", e.idx),    int'(bus_a.min_val),     e.mn);
        chk($sformatf("s%0d_b_above", e.idx), int'(bus_b.state_above), int'(e.above));
        chk($sformatf("s%0d_b_rise", e.idx),  int'(bus_b.rise_pulse),  int'(e.rise));
        chk($sformatf("s%0d_b_fall", e.idx),  int'(bus_b.fall_pulse),  int'(e.fall));
        chk($sformatf("s%0d_b_cnt", e.idx),   int'(bus_b.event_cnt),   bc);
        chk($sformatf("s%0d_b_sat", e.idx),   int'(bus_b.cnt_sat),     (e.cnt >= 3) ? 1 : 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 15, 8, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_cleared("reset_idle");
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 0, 8, 1'b0);

    //   v  d   th c   ab r  f  cnt mx  mn
    step(1, 9,  8, 0,  0, 0, 0, 0,  9,  9);   // 1 rise run starts
    step(1, 10, 8, 0,  0, 0, 0, 0,  10, 9);
    step(1, 12, 8, 0,  1, 1, 0, 1,  12, 9);   // 3 rise
    step(0, 0,  8, 0,  1, 0, 0, 1,  12, 9);   // pulse gone
    step(1, 3,  8, 0,  1, 0, 0, 1,  12, 3);   // 5 fall run with gaps
    step(0, 0,  8, 0,  1, 0, 0, 1,  12, 3);
    step(1, 2,  8, 0,  1, 0, 0, 1,  12, 2);
    step(0, 0,  8, 0,  1, 0, 0, 1,  12, 2);
    step(1, 7,  8, 0,  0, 0, 1, 2,  12, 2);   // 9 fall
    step(0, 0,  8, 0,  0, 0, 0, 2,  12, 2);
    step(1, 9,  8, 0,  0, 0, 0, 2,  12, 2);   // 11 broken by neutral
    step(1, 9,  8, 0,  0, 0, 0, 2,  12, 2);
    step(1, 8,  8, 0,  0, 0, 0, 2,  12, 2);
    step(1, 9,  8, 0,  0, 0, 0, 2,  12, 2);
    step(1, 9,  8, 0,  0, 0, 0, 2,  12, 2);
    step(1, 9,  8, 0,  1, 1, 0, 3,  12, 2);   // 16 rise, narrow counter saturates
    step(1, 5,  8, 0,  1, 0, 0, 3,  12, 2);   // 17 thresh moves mid-run
    step(1, 3,  4, 0,  1, 0, 0, 3,  12, 2);
    step(1, 1,  2, 0,  0, 0, 1, 4,  12, 1);   // 19 fall while narrow counter saturated
    step(1, 9,  8, 0,  0, 0, 0, 4,  12, 1);   // 20 two H then clear
    step(1, 10, 8, 0,  0, 0, 0, 4,  12, 1);
    step(1, 12, 8, 1,  0, 0, 0, 0,  0,  15);  // 22 clear wins over sample
    step(1, 9,  8, 0,  0, 0, 0, 0,  9,  9);
    step(1, 9,  8, 0,  0, 0, 0, 0,  9,  9);
    step(1, 9,  8, 0,  1, 1, 0, 1,  9,  9);   // 25 three fresh H needed
    step(1, 12, 8, 0,  1, 0, 0, 1,  12, 9);
    step(1, 2,  8, 0,  1, 0, 0, 1,  12, 2);
    step(1, 2,  8, 0,  1, 0, 0, 1,  12, 2);
    step(1, 2,  8, 1,  0, 0, 0, 0,  0,  15);  // 29 clear suppresses the fall
    step(1, 4,  8, 0,  0, 0, 0, 0,  4,  4);
    step(0, 0,  8, 0,  0, 0, 0, 0,  4,  4);
    step(1, 15, 8, 0,  0, 0, 0, 0,  15, 4);
    step(1, 15, 8, 0,  0, 0, 0, 0,  15, 4);
    step(1, 15, 8, 0,  1, 1, 0, 1,  15, 4);   // 34 rise, then async reset

    @(posedge clk);
    #5;
    rst_n = 1'b0;
    #1;
    chk_cleared("async_rst");
    #2;
    rst_n = 1'b1;
    drive(1'b0, 0, 8, 1'b0);

    step(1, 9,  8, 0,  0, 0, 0, 0,  9,  9);   // 35 partial run then reset
    step(1, 9,  8, 0,  0, 0, 0, 0,  9,  9);
    @(posedge clk);
    #5;
    rst_n = 1'b0;
    #1;
    chk_cleared("mid_deb_rst");
    #2;
    rst_n = 1'b1;
    drive(1'b0, 0, 8, 1'b0);

    step(1, 9,  8, 0,  0, 0, 0, 0,  9,  9);   // 37 count restarts from zero
    step(1, 9,  8, 0,  0, 0, 0, 0,  9,  9);
    step(1, 9,  8, 0,  1, 1, 0, 1,  9,  9);
    step(0, 0,  8, 0,  1, 0, 0, 1,  9,  9);

    repeat (2) @(posedge clk);
    #5;
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/threshold_monitor.md
Name: threshold_monitor

Overview:
- Downstream consumer of the 4-bit magnitude comparator (`comparator`: inputs A, B; outputs AequalB, greater, lesser).
- Takes a valid-qualified sample stream and compares each sample against a programmable threshold.
- Debounces threshold crossings and emits single-cycle rise/fall event pulses.
- Keeps a saturating event count and the running min/max of accepted samples, for use by status/monitor logic.

Parameters:
- WIDTH, 4, sample and threshold width; must match the comparator instance.
- DEBOUNCE, 3, number of consecutive qualifying samples needed to change state; legal range 1..15.
- CNT_W, 8, event counter width.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset; deassertion is synchronised externally.
- in_valid  in  1  in_data is accepted on any rising edge where this is high.
- in_data  in  WIDTH  sample; drives comparator A.
- thresh  in  WIDTH  threshold; drives comparator B; used live, not latched.
- clear  in  1  synchronous soft clear of all state.
- state_above  out  1  debounced level: 1 = above threshold.
- rise_pulse  out  1  one-cycle pulse on a debounced low-to-high transition.
- fall_pulse  out  1  one-cycle pulse on a debounced high-to-low transition.
- event_cnt  out  CNT_W  count of rise plus fall events; saturating.
- cnt_sat  out  1  high while event_cnt equals all ones.
- max_val  out  WIDTH  largest accepted sample since reset or clear.
- min_val  out  WIDTH  smallest accepted sample since reset or clear.

Behaviour:
- Reset (rst_n low, asynchronous) sets:
  - FSM to S_LOW and the debounce counter to 0.
  - state_above, rise_pulse, fall_pulse, event_cnt and cnt_sat to 0.
  - max_val to 0 and min_val to all ones.
- Reset mid-debounce discards the partial count.
- Sample classification, from the comparator outputs on an accepted sample:
  - greater gives H.
  - lesser gives L.
  - AequalB gives N (neutral: hysteresis hold).
- FSM states: S_LOW, S_LOW_PEND, S_HIGH, S_HIGH_PEND.
  - S_LOW:
    - On H, if DEBOUNCE == 1 go to S_HIGH and pulse rise.
    - On H otherwise, set deb = 1 and go to S_LOW_PEND.
    - On L or N, stay.
  - S_LOW_PEND:
    - On H, deb increments; when deb + 1 == DEBOUNCE go to S_HIGH, pulse rise, set deb = 0.
    - On L or N, go to S_LOW with deb = 0.
  - S_HIGH and S_HIGH_PEND mirror the above with L as the qualifying class and fall_pulse as the pulse.
- Cycles with in_valid = 0 do not advance or break a pending sequence.
- Output timing:
  - All outputs are registered.
  - A pulse appears in the cycle after the edge that accepted the qualifying sample, and lasts exactly one cycle.
  - state_above updates on the same edge that raises the pulse.
  - Pulses are 0 in every other cycle.
- event_cnt:
  - Increments by 1 on each rise or fall event.
  - At all ones it holds (no wrap) and cnt_sat stays 1.
- min/max:
  - Updated on every accepted sample, including N samples.
  - Unsigned compare; ties leave the value unchanged.
  - Both are updated on the same edge as the FSM.
- clear:
  - Same effect as reset, but synchronous.
  - clear together with in_valid: clear wins and the sample is discarded.
  - A pulse pending for the next cycle is suppressed.
- thresh changing mid-sequence: each sample is compared against the thresh present in its own accept cycle, and the pending count is kept.
- Reaching the end state while the counter is saturated still pulses; the count holds.

Decomposition:
- threshold_monitor_pkg holds:
  - the FSM state enum (S_LOW, S_LOW_PEND, S_HIGH, S_HIGH_PEND);
  - the sample-class encoding (CLS_L, CLS_N, CLS_H);
  - default WIDTH, DEBOUNCE and CNT_W constants.
- Sub-module: one instance of the existing `comparator` for the sample-vs-thresh compare.
- The min/max compares are inline; no further sub-modules.

Test Plan:
- Reset and idle: rst_n low with in_valid high and in_data = 15 → state_above = 0, event_cnt = 0, max_val = 0, min_val = 15, no pulses.
- Rise debounce: thresh = 8, DEBOUNCE = 3, samples 9, 10, 12 on consecutive valid cycles → rise_pulse for exactly one cycle after the third accept, state_above = 1, event_cnt = 1.
- Broken sequence and neutral: thresh = 8; samples 9, 9, 8, 9, 9 → no rise; a further 9 → rise, event_cnt = 1.
- Fall with gaps: from state_above = 1, samples 3, (idle), 2, (idle), 7 → fall_pulse after the 7, state_above = 0, event_cnt = 2; min_val = 2, max_val tracks the peak.
- Saturation: CNT_W = 2, drive 4 full rise/fall events → event_cnt stops at 3, cnt_sat = 1, fourth pulse still asserted.
- clear and reset mid-operation:
  - clear asserted with in_valid and sample 12 after two H samples → all state cleared, sample ignored, and three new H samples are needed to rise.
  - Async rst_n pulse mid-cycle → outputs zero immediately, without waiting for a clock edge.
